// File: rtl/router_sync_ctrl.sv
// rtl/router_sync_ctrl.sv - router address latch, FIFO write steering, valid-out and stall timers
module router_sync_ctrl #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_cam,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       ram_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);

  // Last count value before a timeout fires; the counter wraps to 0 there.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Address 2'b11 is the "no destination" code: it never writes and never reports full.
  localparam logic [1:0] ADDR_NONE = 2'b11;

  logic [1:0] addr_q;
  logic [2:0] empty_v;
  logic [2:0] full_v;
  logic [2:0] read_v;
  logic [2:0] vld_v;
  logic [2:0] soft_q;

  assign empty_v = {empty_2, empty_1, empty_0};
  assign full_v  = {full_2, full_1, full_0};
  assign read_v  = {read_enb_2, read_enb_1, read_enb_0};

  // A port has data for its reader whenever its FIFO is not empty.
  assign vld_v     = ~empty_v;
  assign vld_out_0 = vld_v[0];
  assign vld_out_1 = vld_v[1];
  assign vld_out_2 = vld_v[2];

  assign soft_reset_0 = soft_q[0];
  assign soft_reset_1 = soft_q[1];
  assign soft_reset_2 = soft_q[2];

  // Capture the header address while the FSM decodes it; held until the next header.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q <= ADDR_NONE;
    end else if (detect_add) begin
      addr_q <= data_in;
    end
  end

  // Steer the single FSM write strobe to the addressed FIFO and return that FIFO's full flag.
  always_comb begin
    write_enb = 3'b000;
    ram_full  = 1'b0;
    case (addr_q)
      2'b00: begin
        write_enb = {2'b00, write_enb_cam};
        ram_full  = full_v[0];
      end
      2'b01: begin
        write_enb = {1'b0, write_enb_cam, 1'b0};
        ram_full  = full_v[1];
      end
      2'b10: begin
        write_enb = {write_enb_cam, 2'b00};
        ram_full  = full_v[2];
      end
      default: begin
        write_enb = 3'b000;
        ram_full  = 1'b0;
      end
    endcase
  end

  // One independent stall timer per output port.
  for (genvar p = 0; p < 3; p++) begin : g_stall
    logic [CNT_W-1:0] cnt;
    logic             stalled;

    // Data waiting but the reader did not pop it this cycle.
    assign stalled = vld_v[p] & ~read_v[p];

    // Count stalled cycles; on the TIMEOUT-th one, pulse soft_reset for one cycle and restart.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt       <= '0;
        soft_q[p] <= 1'b0;
      end else if (stalled && (cnt == CNT_LAST)) begin
        cnt       <= '0;
        soft_q[p] <= 1'b1;
      end else if (stalled) begin
        cnt       <= cnt + 1'b1;
        soft_q[p] <= 1'b0;
      end else begin
        cnt       <= '0;
        soft_q[p] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_router_sync_ctrl.sv
// tb/tb_router_sync_ctrl.sv - scoreboard bench for router_sync_ctrl against a run-length model
module tb_router_sync_ctrl;

  localparam int TIMEOUT = 30;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       detect_add = 1'b0;
  logic [1:0] data_in = 2'b00;
  logic       write_enb_cam = 1'b0;
  logic       read_enb_0 = 1'b0, read_enb_1 = 1'b0, read_enb_2 = 1'b0;
  logic       empty_0 = 1'b1, empty_1 = 1'b1, empty_2 = 1'b1;
  logic       full_0 = 1'b0, full_1 = 1'b0, full_2 = 1'b0;
  logic [2:0] write_enb;
  logic       ram_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;

  router_sync_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clock(clock), .reset(reset), .detect_add(detect_add), .data_in(data_in),
    .write_enb_cam(write_enb_cam),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2),
    .full_0(full_0), .full_1(full_1), .full_2(full_2),
    .write_enb(write_enb), .ram_full(ram_full),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] we;
    logic       rf;
    logic [2:0] vld;
    logic [2:0] sr;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   pulses_seen = 0;

  int   m_addr = 3;
  int   m_run[3] = '{0, 0, 0};
  string phase = "reset";

  // One clock cycle of stimulus: drive at negedge, predict outputs, queue the prediction.
  task automatic step(input logic rst_i, input logic det, input logic [1:0] din,
                      input logic wcam, input logic [2:0] rd, input logic [2:0] emp,
                      input logic [2:0] fl);
    exp_t e;
    @(negedge clock);
    reset = rst_i; detect_add = det; data_in = din; write_enb_cam = wcam;
    {read_enb_2, read_enb_1, read_enb_0} = rd;
    {empty_2, empty_1, empty_0} = emp;
    {full_2, full_1, full_0} = fl;
    if (rst_i) begin
      m_addr = 3;
      m_run = '{0, 0, 0};
    end
    e.tag = phase;
    e.we  = (wcam && m_addr < 3) ? 3'(1 << m_addr) : 3'b000;
    e.rf  = (m_addr < 3) ? fl[m_addr] : 1'b0;
    e.vld = ~emp;
    e.sr  = 3'b000;
    if (!rst_i) begin
      if (det) m_addr = int'(din);
      for (int p = 0; p < 3; p++) begin
        if (!emp[p] && !rd[p]) begin
          m_run[p]++;
          e.sr[p] = (m_run[p] % TIMEOUT) == 0;
        end else begin
          m_run[p] = 0;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input string tag, input logic [2:0] act,
                       input logic [2:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s [%s] at %0t: got %b expected %b", name, tag, $time, act, req);
    end
  endtask

  // Monitor: comb outputs sampled late in the low phase, soft_reset just after the edge.
  initial begin
    logic [2:0] s_we, s_vld, s_sr;
    logic       s_rf;
    exp_t       e;
    forever begin
      @(negedge clock);
      #3;
      s_we = write_enb; s_rf = ram_full; s_vld = {vld_out_2, vld_out_1, vld_out_0};
      @(posedge clock);
      #1;
      s_sr = {soft_reset_2, soft_reset_1, soft_reset_0};
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("write_enb", e.tag, s_we, e.we);
        check("ram_full", e.tag, {2'b00, s_rf}, {2'b00, e.rf});
        check("vld_out", e.tag, s_vld, e.vld);
        check("soft_reset", e.tag, s_sr, e.sr);
        if (e.sr != 3'b000) pulses_seen++;
      end
    end
  end

  initial begin
    logic [2:0] rnd_rd, rnd_emp, rnd_fl;
    int wait_cyc;

    phase = "reset";
    step(1, 1, 2'b01, 1, 3'b000, 3'b000, 3'b111);
    step(1, 0, 2'b00, 1, 3'b000, 3'b000, 3'b111);

    phase = "steer";
    step(0, 1, 2'b10, 0, 3'b111, 3'b111, 3'b000);
    step(0, 0, 2'b00, 1, 3'b111, 3'b111, 3'b000);
    step(0, 0, 2'b00, 1, 3'b111, 3'b111, 3'b100);
    step(0, 0, 2'b00, 1, 3'b111, 3'b111, 3'b101);
    step(0, 0, 2'b00, 1, 3'b111, 3'b111, 3'b001);
    step(0, 0, 2'b00, 0, 3'b111, 3'b111, 3'b000);

    phase = "invalid";
    step(0, 1, 2'b11, 1, 3'b111, 3'b111, 3'b111);
    step(0, 0, 2'b00, 1, 3'b111, 3'b111, 3'b111);
    step(0, 0, 2'b00, 1, 3'b111, 3'b000, 3'b111);

    phase = "timeout1";
    for (int i = 0; i < 35; i++) step(0, 0, 2'b00, 0, 3'b000, 3'b101, 3'b000);

    phase = "restart1";
    step(0, 0, 2'b00, 0, 3'b010, 3'b101, 3'b000);
    for (int i = 0; i < 29; i++) step(0, 0, 2'b00, 0, 3'b000, 3'b101, 3'b000);
    step(0, 0, 2'b00, 0, 3'b010, 3'b101, 3'b000);
    for (int i = 0; i < 29; i++) step(0, 0, 2'b00, 0, 3'b000, 3'b101, 3'b000);
    step(0, 0, 2'b00, 0, 3'b010, 3'b101, 3'b000);

    phase = "concurrent";
    for (int i = 0; i < 62; i++) step(0, 1, 2'b00, 1, 3'b010, 3'b000, 3'b000);

    phase = "reset_mid";
    step(0, 0, 2'b00, 0, 3'b111, 3'b111, 3'b000);
    for (int i = 0; i < 17; i++) step(0, 0, 2'b00, 0, 3'b000, 3'b110, 3'b000);
    step(1, 0, 2'b00, 1, 3'b000, 3'b110, 3'b111);
    for (int i = 0; i < 32; i++) step(0, 0, 2'b00, 0, 3'b000, 3'b110, 3'b000);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < 3; p++) begin
        rnd_rd[p]  = ($urandom_range(0, 39) == 0);
        rnd_emp[p] = ($urandom_range(0, 9) == 0);
      end
      rnd_fl = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 599) == 0), ($urandom_range(0, 7) == 0),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rnd_rd, rnd_emp, rnd_fl);
    end

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clock);
      wait_cyc++;
    end
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    total++;
    if (pulses_seen < 3) begin
      bad++;
      $display("FAIL pulse_coverage: got %0d expected at least 3", pulses_seen);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
